// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts decoded ADDI/LW/BNE fields over valid/ready,
// validates and encodes them, and writes the words sequentially into instruction memory.
module instr_encoder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned OP_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   in_op,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  full,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [OP_WIDTH-1:0]   OP_ADDI   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0]   OP_LW     = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0]   OP_BNE    = OP_WIDTH'(2);
    localparam logic [1:0]            CODE_OK   = 2'd0;
    localparam logic [1:0]            CODE_RANGE = 2'd1;
    localparam logic [1:0]            CODE_ALIGN = 2'd2;
    localparam logic [1:0]            CODE_OP   = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] PTR_STEP  = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

    state_t                state;
    logic [OP_WIDTH-1:0]   op_q;
    logic [4:0]            rd_q;
    logic [4:0]            rs1_q;
    logic [4:0]            rs2_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  we_q;

    logic [DATA_WIDTH-1:0] enc_word;
    logic [1:0]            enc_code;
    logic                  i_fits;
    logic                  b_fits;

    // Range checks reduce to sign-extension tests: all bits above the field must match.
    always_comb begin
        enc_word = '0;
        enc_code = CODE_OK;
        i_fits   = (&imm_q[DATA_WIDTH-1:11]) | ~(|imm_q[DATA_WIDTH-1:11]);
        b_fits   = (&imm_q[DATA_WIDTH-1:12]) | ~(|imm_q[DATA_WIDTH-1:12]);
        case (op_q)
            OP_ADDI: begin
                enc_word = DATA_WIDTH'({imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011});
                if (!i_fits) enc_code = CODE_RANGE;
            end
            OP_LW: begin
                enc_word = DATA_WIDTH'({imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011});
                if (!i_fits) enc_code = CODE_RANGE;
            end
            OP_BNE: begin
                enc_word = DATA_WIDTH'({imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b001,
                                        imm_q[4:1], imm_q[11], 7'b1100011});
                if (imm_q[0])     enc_code = CODE_ALIGN;
                else if (!b_fits) enc_code = CODE_RANGE;
            end
            default: enc_code = CODE_OP;
        endcase
    end

    // Control FSM with registered write port and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            ptr       <= '0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= CODE_OK;
        end else if (clear) begin
            state    <= IDLE;
            ptr      <= '0;
            we_q     <= 1'b0;
            full     <= 1'b0;
            err      <= 1'b0;
            err_code <= CODE_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !full) begin
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        rs1_q <= in_rs1;
                        rs2_q <= in_rs2;
                        imm_q <= in_imm;
                        state <= ENC;
                    end
                end
                ENC: begin
                    if (enc_code == CODE_OK) begin
                        we_q      <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= enc_word;
                        state     <= WR;
                    end else begin
                        err      <= 1'b1;
                        err_code <= enc_code;
                        state    <= IDLE;
                    end
                end
                WR: begin
                    we_q  <= 1'b0;
                    ptr   <= ptr + PTR_STEP;
                    if (ptr == PTR_LAST) full <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A clear or reset in the write cycle suppresses the strobe immediately.
    assign in_ready = (state == IDLE) & ~full & ~clear & ~rst;
    assign mem_we   = we_q & ~clear & ~rst;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: cycle-level reference model plus directed vectors,
// with a second narrow-address instance for the full/wrap behaviour.
module tb_instr_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, in_valid;
    logic [1:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_ready, mem_we, full, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  err_code;

    logic        b_clear, b_valid;
    logic [1:0]  b_op;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [31:0] b_imm;
    logic        b_ready, b_we, b_full, b_err;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [1:0]  b_code;

    instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .OP_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .full(full), .err(err), .err_code(err_code)
    );

    instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OP_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_valid), .in_ready(b_ready),
        .in_op(b_op), .in_rd(b_rd), .in_rs1(b_rs1), .in_rs2(b_rs2), .in_imm(b_imm),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .full(b_full), .err(b_err), .err_code(b_code)
    );

    int cmp_count  = 0;
    int fail_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference encoding from the instruction format tables: {err_code, word}.
    function automatic logic [33:0] model_enc(input int op, input int rd, input int rs1,
                                              input int rs2, input int imm);
        logic [31:0] u, w;
        logic [1:0]  c;
        u = imm;
        w = 32'h0;
        c = 2'd0;
        if (op == 0 || op == 1) begin
            if (imm < -2048 || imm > 2047) c = 2'd1;
            w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7)
              | ((op == 1) ? 32'h2003 : 32'h0013);
        end else if (op == 2) begin
            if (imm % 2 != 0) c = 2'd2;
            else if (imm < -4096 || imm > 4094) c = 2'd1;
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (32'(rs2) << 20)
              | (32'(rs1) << 15) | (32'h1 << 12) | (((u >> 1) & 15) << 8)
              | (((u >> 11) & 1) << 7) | 32'h63;
        end else begin
            c = 2'd3;
        end
        return {c, w};
    endfunction

    int          cyc = 0;
    bit          armed = 0;
    int          m_ptr = 0;
    bit          m_full = 0, m_err = 0;
    logic [1:0]  m_code = 2'd0;
    logic [7:0]  m_addr = 8'h0;
    logic [31:0] m_data = 32'h0;
    int          busy_end = -1;
    bit          pw = 0, pe = 0;
    int          pw_due = 0, pe_due = 0;
    logic [7:0]  pw_addr = 8'h0;
    logic [31:0] pw_data = 32'h0;
    logic [1:0]  pe_code = 2'd0;
    logic [39:0] wlog[$];
    logic [35:0] blog[$];

    task automatic reset_model(input bit hard);
        m_ptr = 0; m_full = 0; m_err = 0; m_code = 2'd0;
        pw = 0; pe = 0; busy_end = cyc;
        if (hard) begin m_addr = 8'h0; m_data = 32'h0; end
    endtask

    // Model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        bit          exp_we, exp_rdy;
        logic [33:0] r;
        if (b_we) blog.push_back({b_addr, b_wdata});
        if (!armed) begin
            if (rst) begin armed = 1; reset_model(1); end
        end else begin
            if (pe && pe_due == cyc) begin m_err = 1; m_code = pe_code; pe = 0; end
            if (pw && pw_due == cyc) begin m_addr = pw_addr; m_data = pw_data; end
            exp_we  = pw && (pw_due == cyc) && !clear && !rst;
            exp_rdy = (cyc > busy_end) && !m_full && !clear && !rst;
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("full", 32'(full), 32'(m_full));
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata, m_data);
            if (mem_we) wlog.push_back({mem_addr, mem_wdata});
            if (rst) reset_model(1);
            else if (clear) reset_model(0);
            else begin
                if (pw && pw_due == cyc) begin
                    pw = 0;
                    if (m_ptr == 252) m_full = 1;
                    m_ptr = (m_ptr + 4) % 256;
                end
                if (in_valid && exp_rdy) begin
                    r = model_enc(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2),
                                  $signed(in_imm));
                    if (r[33:32] == 2'd0) begin
                        pw = 1; pw_due = cyc + 2; pw_addr = 8'(m_ptr); pw_data = r[31:0];
                        busy_end = cyc + 2;
                    end else begin
                        pe = 1; pe_due = cyc + 2; pe_code = r[33:32];
                        busy_end = cyc + 1;
                    end
                end
            end
        end
        cyc++;
    end

    task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
        bit ok;
        ok = 0;
        in_op = 2'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 32'(imm);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic expect_log(input string name, input int idx, input logic [7:0] a,
                              input logic [31:0] d);
        if (idx < wlog.size()) begin
            chk({name, "_addr"}, 32'(wlog[idx][39:32]), 32'(a));
            chk({name, "_data"}, wlog[idx][31:0], d);
        end else begin
            chk({name, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    task automatic b_send(input int rd, input int imm);
        bit ok;
        ok = 0;
        b_op = 2'd0; b_rd = 5'(rd); b_rs1 = 5'd0; b_rs2 = 5'd0; b_imm = 32'(imm);
        b_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (b_ready) ok = 1;
        end
        if (!ok) chk("b_send_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] m;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_op = 2'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0;
        b_clear = 1'b0; b_valid = 1'b0;
        b_op = 2'd0; b_rd = 5'd0; b_rs1 = 5'd0; b_rs2 = 5'd0; b_imm = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        m = model_enc(0, 5, 0, 0, 10);   chk("model_addi", m[31:0], 32'h00A00293);
        m = model_enc(1, 1, 2, 0, 4);    chk("model_lw", m[31:0], 32'h00412083);
        m = model_enc(2, 0, 1, 0, -8);   chk("model_bne", m[31:0], 32'hFE009CE3);
        m = model_enc(2, 0, 1, 2, 4095); chk("model_prio", 32'(m[33:32]), 32'd2);

        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Basic ADDI with latency check, then the pointer has advanced.
        wlog.delete();
        send(0, 5, 0, 0, 10);
        in_valid = 1'b0;
        @(negedge clk); chk("lat_enc_we", 32'(mem_we), 32'd0);
        @(negedge clk); chk("lat_wr_we", 32'(mem_we), 32'd1);
        chk("lat_wr_data", mem_wdata, 32'h00A00293);
        idle(3);
        send(0, 6, 5, 0, -1);
        idle(4);
        expect_log("addi0", 0, 8'h00, 32'h00A00293);
        expect_log("addi1", 1, 8'h04, 32'hFFF28313);

        // LW then BNE back-to-back with valid held.
        pulse_clear();
        wlog.delete();
        send(1, 1, 2, 0, 4);
        send(2, 0, 1, 0, -8);
        idle(4);
        expect_log("lw", 0, 8'h00, 32'h00412083);
        expect_log("bne", 1, 8'h04, 32'hFE009CE3);

        // Error codes, priority, sticky err, and writes continuing while err is set.
        pulse_clear();
        wlog.delete();
        send(0, 1, 1, 0, 2048);   idle(3);
        chk("err_range", 32'({err, err_code}), 32'h5);
        send(2, 0, 1, 2, 3);      idle(3);
        chk("err_align", 32'(err_code), 32'd2);
        send(3, 1, 1, 1, 0);      idle(3);
        chk("err_op", 32'(err_code), 32'd3);
        send(2, 0, 1, 2, 4095);   idle(3);
        chk("err_prio", 32'(err_code), 32'd2);
        send(2, 0, 1, 2, 4096);   idle(3);
        chk("err_b_hi", 32'(err_code), 32'd1);
        send(2, 0, 1, 2, -4098);  idle(3);
        chk("err_b_lo", 32'(err_code), 32'd1);
        chk("err_nowrite", 32'(wlog.size()), 32'd0);
        send(0, 1, 0, 0, 2047);
        send(0, 1, 0, 0, -2048);
        send(2, 0, 1, 2, 4094);
        send(2, 0, 1, 2, -4096);
        idle(4);
        expect_log("i_max", 0, 8'h00, 32'h7FF00093);
        expect_log("i_min", 1, 8'h04, 32'h80000093);
        expect_log("b_max", 2, 8'h08, 32'h7E209FE3);
        expect_log("b_min", 3, 8'h0C, 32'h80209063);
        chk("err_sticky", 32'({err, err_code}), 32'h5);
        pulse_clear();
        chk("err_cleared", 32'({err, err_code}), 32'h0);

        // Clear during the write cycle drops the op.
        wlog.delete();
        send(0, 2, 0, 0, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk); chk("clr_wr_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        idle(3);
        chk("clr_wr_nolog", 32'(wlog.size()), 32'd0);
        send(0, 2, 0, 0, 1);
        idle(4);
        expect_log("after_clr", 0, 8'h00, 32'h00100113);

        // Reset during the encode cycle.
        wlog.delete();
        send(1, 3, 4, 0, 8);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        chk("rst_enc_nolog", 32'(wlog.size()), 32'd0);
        chk("rst_enc_wdata", mem_wdata, 32'h0);
        chk("rst_enc_addr", 32'(mem_addr), 32'h0);

        // Clear wins over a simultaneous valid.
        clear = 1'b1; in_valid = 1'b1;
        in_op = 2'd0; in_rd = 5'd7; in_rs1 = 5'd0; in_imm = 32'd3;
        @(negedge clk); chk("clr_valid_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        idle(4);
        chk("clr_valid_nolog", 32'(wlog.size()), 32'd0);

        // Narrow instance: fill all four slots, observe full, then clear and restart.
        blog.delete();
        for (int i = 0; i < 4; i++) b_send(i + 1, i);
        chk("b_count", 32'(blog.size()), 32'd4);
        for (int i = 0; i < 4 && i < blog.size(); i++) begin
            m = model_enc(0, i + 1, 0, 0, i);
            chk("b_addr", 32'(blog[i][35:32]), 32'(4 * i));
            chk("b_data", blog[i][31:0], m[31:0]);
        end
        if (blog.size() > 3) chk("b_data3_lit", blog[3][31:0], 32'h00300213);
        chk("b_full", 32'(b_full), 32'd1);
        b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("b_full_ready", 32'(b_ready), 32'd0);
        end
        chk("b_full_nolog", 32'(blog.size()), 32'd4);
        @(posedge clk); #1;
        b_clear = 1'b1;
        @(negedge clk); chk("b_clr_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        b_clear = 1'b0;
        @(negedge clk);
        chk("b_after_ready", 32'(b_ready), 32'd1);
        chk("b_after_full", 32'(b_full), 32'd0);
        @(posedge clk); #1;
        b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (blog.size() > 4) chk("b_restart_addr", 32'(blog[4][35:32]), 32'h0);
        else chk("b_restart_missing", 32'(blog.size()), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Writer-side companion to the instruction decode path.
- Accepts decoded instruction fields (op, rd, rs1, rs2, imm) over a valid/ready handshake and encodes them into RV32I machine words.
- Covers the ops the control unit decodes: ADDI, LW, BNE.
- Writes each word sequentially into instruction memory; used by test/boot logic to build programs without a host assembler.

Parameters:
- DATA_WIDTH, 32, instruction word width (fixed at 32 for RV32I).
- ADDR_WIDTH, 8, byte-address width of instruction memory write port; memory holds 2^(ADDR_WIDTH-2) words.
- OP_WIDTH, 2, width of op select.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  sync: write address to 0, clears full and err, aborts in-flight op.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- in_op  input  OP_WIDTH  0=ADDI, 1=LW, 2=BNE, 3=reserved.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2 (BNE only).
- in_imm  input  DATA_WIDTH  signed two's-complement immediate/offset.
- mem_we  output  1  instruction memory write strobe, one cycle.
- mem_addr  output  ADDR_WIDTH  byte address of write, word aligned.
- mem_wdata  output  DATA_WIDTH  encoded instruction word.
- full  output  1  last word slot written; no further accepts until clear.
- err  output  1  sticky encode error.
- err_code  output  2  0=none, 1=imm out of range, 2=branch offset misaligned, 3=reserved op.

Behaviour:
- Reset (rst=1 at edge): state IDLE; in_ready=0 during the reset cycle; mem_we=0, mem_addr=0, mem_wdata=0, full=0, err=0, err_code=0.
- FSM states IDLE -> ENC -> WR -> IDLE.
- in_ready=1 only in IDLE with full=0 and clear=0.
- Handshake: transfer when in_valid & in_ready at edge. Fields are registered and state goes to ENC. Fields ignored at all other times.
- ENC, one cycle: validate and encode into an internal register.
  - Valid: go to WR.
  - Invalid: err=1, err_code set, return to IDLE, no write.
- WR, one cycle: mem_we=1, mem_addr = current pointer, mem_wdata = encoded word. At the next edge the pointer advances by 4 and state returns to IDLE.
- Latency: handshake at edge N, mem_we high in cycle N+2. Throughput is one instruction per 3 cycles.
- ADDI encoding: imm[11:0] | rs1 | 000 | rd | 0010011.
- LW encoding: imm[11:0] | rs1 | 010 | rd | 0000011.
- BNE encoding: imm[12] | imm[10:5] | rs2 | rs1 | 001 | imm[4:1] | imm[11] | 1100011.
- Range checks:
  - I-type imm must be -2048..2047.
  - B-type imm must be -4096..4094 and even. Misalignment is checked before range; err_code=2 takes priority.
- Reserved op: err_code=3.
- Error reporting: err stays set until clear or rst. A later error overwrites err_code. Valid instructions still encode and write while err=1.
- Full and wrap-around: a write at pointer 2^ADDR_WIDTH-4 sets full=1 and wraps the pointer to 0. in_ready stays 0 until clear.
- clear in any state: state IDLE, pointer 0, full=0, err=0, err_code=0, no mem_we that cycle.
  - An op in ENC/WR is dropped.
  - clear and in_valid in the same cycle: clear wins, no transfer.
- rst mid-operation behaves as clear, plus mem_wdata=0.
- mem_wdata and mem_addr hold their last values outside WR. Only mem_we qualifies them.

Test Plan:
- Reset, then ADDI rd=5 rs1=0 imm=10 -> two cycles later mem_we=1, mem_addr=0x00, mem_wdata=0x00A00293; next accept writes to 0x04.
- LW rd=1 rs1=2 imm=4, then BNE rs1=1 rs2=0 imm=-8 back-to-back with in_valid held -> writes 0x00412083 @0x00 and 0xFE009CE3 @0x04; in_ready low in ENC/WR cycles.
- ADDI imm=2048 -> err=1, err_code=1, no mem_we, pointer unchanged; then BNE imm=3 -> err_code=2; then op=3 -> err_code=3; then clear -> err=0.
- ADDR_WIDTH=4: four valid ADDIs -> writes at 0x0,0x4,0x8,0xC, full=1 after 4th, in_ready=0 with in_valid held; clear -> pointer 0, in_ready=1.
- Assert clear in WR cycle and separately rst in ENC cycle -> no mem_we, pointer 0, FSM IDLE; clear with in_valid=1 -> no transfer that cycle.
